// File: rtl/bpg_pkg.sv
// Shared definitions for the pattern buffer controller: playback states and the
// default pattern RAM address width.
package bpg_pkg;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;
endpackage

// File: rtl/pattern_addr_counter.sv
// Read-address counter for the active pattern buffer: advances on step, wraps to
// zero at the last pattern address and flags that step with a one-cycle pulse.
module pattern_addr_counter
  import bpg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              clear,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pattern_end,
  output logic              boundary
);

  // >= rather than == so the address can never run past the last entry
  assign boundary = step && (rd_addr >= len);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr     <= '0;
      pattern_end <= 1'b0;
    end else begin
      pattern_end <= boundary;
      if (clear || boundary)
        rd_addr <= '0;
      else if (step)
        rd_addr <= rd_addr + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_buffer_ctrl.sv
// Double-buffered pattern playback controller: host loads the standby buffer,
// the swap happens at a pattern boundary so playback never sees a partial load.
module pattern_buffer_ctrl
  import bpg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              commit,
  input  logic [ADDR_W-1:0] length,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              active_buffer,
  output logic              active,
  output logic              ready,
  output logic              load_complete,
  output logic              preload,
  output logic              pattern_end
);

  state_t            state, state_nxt;
  logic              valid, valid_nxt;
  logic [ADDR_W-1:0] len_active, len_active_nxt;
  logic [ADDR_W-1:0] len_standby, len_standby_nxt;
  logic              active_buffer_nxt, active_nxt, ready_nxt;
  logic              load_complete_nxt, preload_nxt;
  logic              step, clear, boundary;

  assign step = tick && (state != ST_IDLE);

  pattern_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .clear       (clear),
    .len         (len_active),
    .rd_addr     (rd_addr),
    .pattern_end (pattern_end),
    .boundary    (boundary)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      valid         <= 1'b0;
      len_active    <= '0;
      len_standby   <= '0;
      active_buffer <= 1'b0;
      active        <= 1'b0;
      ready         <= 1'b0;
      load_complete <= 1'b0;
      preload       <= 1'b0;
    end else begin
      state         <= state_nxt;
      valid         <= valid_nxt;
      len_active    <= len_active_nxt;
      len_standby   <= len_standby_nxt;
      active_buffer <= active_buffer_nxt;
      active        <= active_nxt;
      ready         <= ready_nxt;
      load_complete <= load_complete_nxt;
      preload       <= preload_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    valid_nxt         = valid;
    len_active_nxt    = len_active;
    len_standby_nxt   = len_standby;
    active_buffer_nxt = active_buffer;
    active_nxt        = active;
    ready_nxt         = ready;
    load_complete_nxt = load_complete;
    preload_nxt       = preload;
    clear             = 1'b0;

    case (state)
      ST_IDLE: begin
        if (commit) begin
          active_buffer_nxt = ~active_buffer;
          len_active_nxt    = length;
          valid_nxt         = 1'b1;
          preload_nxt       = 1'b0;
          ready_nxt         = 1'b1;
        end else if (we && !valid) begin
          preload_nxt = 1'b1;
        end
        if (start && !stop && ready) begin
          state_nxt  = ST_RUN;
          active_nxt = 1'b1;
          ready_nxt  = 1'b0;
          clear      = 1'b1;
        end
      end
      ST_RUN, ST_STOP_PEND: begin
        if (boundary) begin
          // a pending load wins; otherwise a coincident commit swaps directly
          if (load_complete) begin
            active_buffer_nxt = ~active_buffer;
            len_active_nxt    = len_standby;
            load_complete_nxt = 1'b0;
          end else if (commit) begin
            active_buffer_nxt = ~active_buffer;
            len_active_nxt    = length;
          end
        end else if (commit && !load_complete) begin
          len_standby_nxt   = length;
          load_complete_nxt = 1'b1;
        end
        if (state == ST_RUN) begin
          if (stop) state_nxt = ST_STOP_PEND;
        end else if (boundary) begin
          state_nxt  = ST_IDLE;
          active_nxt = 1'b0;
          ready_nxt  = valid;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_buffer_ctrl.sv
// Directed and randomized check of pattern_buffer_ctrl against a cycle-level
// behavioural model of the playback/double-buffer rules.
module tb_pattern_buffer_ctrl;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset, we, commit, start, stop, tick;
  logic [AW-1:0] length;
  logic [AW-1:0] rd_addr;
  logic          active_buffer, active, ready, load_complete, preload, pattern_end;

  int checks = 0;
  int passed = 0;

  // model state
  bit            m_play, m_stopping, m_valid, m_buf, m_std_full, m_pre, m_end;
  int            m_addr, m_len, m_std_len;

  always #5 clk = ~clk;

  pattern_buffer_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .commit(commit), .length(length),
    .start(start), .stop(stop), .tick(tick), .rd_addr(rd_addr),
    .active_buffer(active_buffer), .active(active), .ready(ready),
    .load_complete(load_complete), .preload(preload), .pattern_end(pattern_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input bit r, w, c, input int l, input bit s, p, t);
    bit hit, was_stop, v0;
    if (r) begin
      m_play = 0; m_stopping = 0; m_valid = 0; m_buf = 0; m_std_full = 0;
      m_pre = 0; m_end = 0; m_addr = 0; m_len = 0; m_std_len = 0;
    end else if (!m_play) begin
      v0 = m_valid;
      m_end = 0;
      if (c) begin m_buf = ~m_buf; m_len = l; m_valid = 1; m_pre = 0; end
      else if (w && !m_valid) m_pre = 1;
      if (s && !p && v0) begin m_play = 1; m_addr = 0; m_stopping = 0; end
    end else begin
      was_stop = m_stopping;
      hit = t && (m_addr == m_len);
      m_end = hit;
      if (hit) begin
        m_addr = 0;
        if (m_std_full) begin m_buf = ~m_buf; m_len = m_std_len; m_std_full = 0; end
        else if (c) begin m_buf = ~m_buf; m_len = l; end
        if (was_stop) begin m_play = 0; m_stopping = 0; end
      end else begin
        if (t) m_addr = m_addr + 1;
        if (c && !m_std_full) begin m_std_full = 1; m_std_len = l; end
      end
      if (!was_stop && p) m_stopping = 1;
    end
  endtask

  task automatic step(input bit r, w, c, input logic [AW-1:0] l, input bit s, p, t);
    reset = r; we = w; commit = c; length = l; start = s; stop = p; tick = t;
    @(posedge clk);
    #1;
    model(r, w, c, int'(l), s, p, t);
    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
    chk("active_buffer", 32'(active_buffer), 32'(m_buf));
    chk("active", 32'(active), 32'(m_play));
    chk("ready", 32'(ready), 32'(m_valid && !m_play));
    chk("load_complete", 32'(load_complete), 32'(m_std_full));
    chk("preload", 32'(preload), 32'(m_pre));
    chk("pattern_end", 32'(pattern_end), 32'(m_end));
  endtask

  task automatic tk();
    step(0, 0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; we = 0; commit = 0; length = '0; start = 0; stop = 0; tick = 0;

    // reset state, preload, first commit
    step(1, 0, 0, '0, 0, 0, 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_buf", 32'(active_buffer), 0);
    step(0, 1, 0, '0, 0, 0, 0);
    chk("preload_set", 32'(preload), 1);
    step(0, 0, 1, 13'd3, 0, 0, 0);
    chk("preload_clr", 32'(preload), 0);
    chk("commit_buf", 32'(active_buffer), 1);
    chk("commit_ready", 32'(ready), 1);

    // start and 8 ticks over a 4-entry pattern
    step(0, 0, 0, '0, 1, 0, 0);
    chk("start_active", 32'(active), 1);
    chk("start_ready", 32'(ready), 0);
    for (int i = 0; i < 8; i++) begin
      tk();
      chk("seq_addr", 32'(rd_addr), 32'((i + 1) % 4));
      chk("seq_end", 32'(pattern_end), 32'(i == 3 || i == 7));
    end

    // mid-pattern commit length=1, second commit locked out
    tk(); tk();
    step(0, 0, 1, 13'd1, 0, 0, 0);
    chk("lc_set", 32'(load_complete), 1);
    step(0, 1, 1, 13'd2, 0, 0, 0);
    chk("lc_locked", 32'(load_complete), 1);
    tk();
    tk();
    chk("swap_buf", 32'(active_buffer), 0);
    chk("swap_lc", 32'(load_complete), 0);
    for (int i = 0; i < 4; i++) begin
      tk();
      chk("len1_addr", 32'(rd_addr), 32'((i + 1) % 2));
    end

    // back to length 3, then stop at rd_addr=1
    step(0, 0, 1, 13'd3, 0, 0, 0);
    tk(); tk();
    chk("swap3_buf", 32'(active_buffer), 1);
    tk();
    step(0, 0, 0, '0, 0, 1, 0);
    chk("stop_pend_active", 32'(active), 1);
    tk(); tk();
    chk("stop_pend_addr", 32'(rd_addr), 3);
    chk("stop_pend_active2", 32'(active), 1);
    tk();
    chk("stopped_active", 32'(active), 0);
    chk("stopped_ready", 32'(ready), 1);

    // zero-length pattern: every tick is a boundary
    step(0, 0, 1, 13'd0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("len0_addr", 32'(rd_addr), 0);
      chk("len0_end", 32'(pattern_end), 1);
    end
    step(0, 0, 0, '0, 0, 1, 1);
    tk();
    chk("len0_idle", 32'(active), 0);

    // reset mid-run, then start+stop together
    step(0, 0, 1, 13'd3, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    tk(); tk();
    chk("pre_rst_addr", 32'(rd_addr), 2);
    step(1, 1, 1, 13'd5, 1, 0, 1);
    chk("midrst_addr", 32'(rd_addr), 0);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_buf", 32'(active_buffer), 0);
    step(0, 0, 1, 13'd2, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 0);
    chk("startstop_active", 32'(active), 0);
    chk("startstop_ready", 32'(ready), 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 13'($urandom_range(0, 4)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
